// File: rtl/dense_controller.sv
// Sequencer for one fully-connected layer pass: load inputs, accumulate bias + sum(x*w)
// per neuron into the outputs RAM, then stream the results downstream.
module dense_controller #(
  parameter int IN_COUNT  = 16,
  parameter int OUT_COUNT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic inValid,
  output logic inReady,
  output logic outValid,
  input  logic outReady,
  output logic done,
  output logic err,
  input  logic gotData,
  input  logic mulDone,
  input  logic calcDone,
  input  logic putData,
  output logic clear,
  output logic busy,
  output logic rdi,
  output logic wri,
  output logic rdo,
  output logic wro,
  output logic inCntEn,
  output logic clearReg,
  output logic WorB,
  output logic load,
  output logic outCntEn
);

  localparam int BW = (IN_COUNT  > 1) ? $clog2(IN_COUNT)  : 1;
  localparam int NW = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(IN_COUNT - 1);
  localparam logic [NW-1:0] NRN_LAST  = NW'(OUT_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_LOAD = 3'd2,
    S_ACC0 = 3'd3,
    S_BIAS = 3'd4,
    S_MAC  = 3'd5,
    S_OUT  = 3'd6,
    S_FIN  = 3'd7
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [BW-1:0] beat_cnt_r;
  logic [NW-1:0] nrn_cnt_r;
  logic          beat_term_s;
  logic          nrn_term_s;
  logic          flag_err_s;
  logic          err_r;

  assign err         = err_r;
  assign beat_term_s = (beat_cnt_r == BEAT_LAST);
  assign nrn_term_s  = (nrn_cnt_r == NRN_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_s  = state_r;
    inReady  = 1'b0;
    outValid = 1'b0;
    done     = 1'b0;
    clear    = 1'b0;
    busy     = 1'b1;
    rdi      = 1'b0;
    wri      = 1'b0;
    rdo      = 1'b0;
    wro      = 1'b0;
    inCntEn  = 1'b0;
    clearReg = 1'b0;
    WorB     = 1'b0;
    load     = 1'b0;
    outCntEn = 1'b0;
    case (state_r)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_s = S_CLR;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CLR: begin
        clear    = 1'b1;
        clearReg = 1'b1;
        state_s  = S_LOAD;
      end
      S_LOAD: begin
        inReady = 1'b1;
        if (inValid) begin
          wri     = 1'b1;
          inCntEn = 1'b1;
          if (gotData) begin
            state_s = S_ACC0;
          end else begin
            state_s = S_LOAD;
          end
        end else begin
          state_s = S_LOAD;
        end
      end
      S_ACC0: begin
        clearReg = 1'b1;
        state_s  = S_BIAS;
      end
      S_BIAS: begin
        WorB    = 1'b1;
        load    = 1'b1;
        state_s = S_MAC;
      end
      S_MAC: begin
        rdi     = 1'b1;
        load    = 1'b1;
        inCntEn = 1'b1;
        // The last product goes straight into the outputs RAM alongside the accumulate
        if (mulDone) begin
          wro      = 1'b1;
          outCntEn = 1'b1;
          if (calcDone) begin
            state_s = S_OUT;
          end else begin
            state_s = S_ACC0;
          end
        end else begin
          state_s = S_MAC;
        end
      end
      S_OUT: begin
        rdo      = 1'b1;
        outValid = 1'b1;
        if (outReady) begin
          outCntEn = 1'b1;
          if (putData) begin
            state_s = S_FIN;
          end else begin
            state_s = S_OUT;
          end
        end else begin
          state_s = S_OUT;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        busy    = 1'b0;
        state_s = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_s = S_IDLE;
      end
    endcase
  end

  // Shadow copies of the datapath beat and neuron counters
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      beat_cnt_r <= '0;
      nrn_cnt_r  <= '0;
    end else begin
      if (inCntEn) begin
        beat_cnt_r <= beat_term_s ? '0 : beat_cnt_r + BW'(1);
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
      if (outCntEn) begin
        nrn_cnt_r <= nrn_term_s ? '0 : nrn_cnt_r + NW'(1);
      end else begin
        nrn_cnt_r <= nrn_cnt_r;
      end
    end
  end

  // Flag cross-check, only in the states that consume each flag
  always_comb begin
    flag_err_s = 1'b0;
    case (state_r)
      S_LOAD:  flag_err_s = (gotData != beat_term_s);
      S_MAC:   flag_err_s = (mulDone != beat_term_s) || (calcDone != nrn_term_s);
      S_OUT:   flag_err_s = (putData != nrn_term_s);
      default: flag_err_s = 1'b0;
    endcase
  end

  // Sticky error; a new start from IDLE wipes it
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if ((state_r == S_IDLE) && start) begin
      err_r <= 1'b0;
    end else if (flag_err_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

endmodule

// File: tb/tb_dense_controller.sv
// Randomised scoreboard bench for dense_controller with a behavioural datapath around it.
module tb_dense_controller;

  localparam int IN  = 4;
  localparam int OUT = 3;
  localparam int LAT = 1 + IN + OUT * (IN + 2) + OUT + 1;

  logic clk = 1'b0;
  logic rst, start, inValid, outReady;
  logic inReady, outValid, done, err;
  logic gotData, mulDone, calcDone, putData;
  logic clear, busy, rdi, wri, rdo, wro, inCntEn, clearReg, WorB, load, outCntEn;

  int x_vec [IN];
  int w_mat [OUT][IN];
  int b_vec [OUT];
  int in_ram [IN];
  int out_ram [OUT];
  int in_cnt_m = 0, out_cnt_m = 0, acc_m = 0, fed = 0, popped = 0, cyc = 0;
  int data_in, data_out, mac_prod;
  bit force_cd = 1'b0;
  bit sb_en = 1'b1;
  int sb[$];
  int checks = 0, errors = 0;
  int done_cnt = 0, done_cyc = 0;
  logic [14:0] all_outs;

  always #5 clk = ~clk;

  dense_controller #(.IN_COUNT(IN), .OUT_COUNT(OUT)) dut (
    .clk(clk), .rst(rst), .start(start), .inValid(inValid), .inReady(inReady),
    .outValid(outValid), .outReady(outReady), .done(done), .err(err),
    .gotData(gotData), .mulDone(mulDone), .calcDone(calcDone), .putData(putData),
    .clear(clear), .busy(busy), .rdi(rdi), .wri(wri), .rdo(rdo), .wro(wro),
    .inCntEn(inCntEn), .clearReg(clearReg), .WorB(WorB), .load(load), .outCntEn(outCntEn)
  );

  assign all_outs = {inReady, outValid, done, err, clear, busy, rdi, wri, rdo, wro,
                     inCntEn, clearReg, WorB, load, outCntEn};

  // Datapath environment: counters with terminal flags, RAMs and the accumulator
  assign gotData  = (in_cnt_m == IN - 1);
  assign mulDone  = (in_cnt_m == IN - 1);
  assign calcDone = (out_cnt_m == OUT - 1) || (force_cd && out_cnt_m == OUT - 2);
  assign putData  = (out_cnt_m == OUT - 1);

  always_comb begin
    data_in  = (fed < IN) ? x_vec[fed] : 0;
    mac_prod = rdi ? in_ram[in_cnt_m] * w_mat[out_cnt_m][in_cnt_m] : 0;
    data_out = rdo ? out_ram[out_cnt_m] : 0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clear) begin
      in_cnt_m <= 0; out_cnt_m <= 0; fed <= 0; popped <= 0;
    end else begin
      if (inCntEn) in_cnt_m <= (in_cnt_m == IN - 1) ? 0 : in_cnt_m + 1;
      if (outCntEn) out_cnt_m <= (out_cnt_m == OUT - 1) ? 0 : out_cnt_m + 1;
      if (inValid && inReady) fed <= fed + 1;
      if (outValid && outReady) popped <= popped + 1;
    end
    if (wri) in_ram[in_cnt_m] <= data_in;
    if (clearReg) acc_m <= 0;
    else if (load) acc_m <= WorB ? b_vec[out_cnt_m] : acc_m + mac_prod;
    if (wro) out_ram[out_cnt_m] <= acc_m + mac_prod;
  end

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: handshake rules, held results under back-pressure, scoreboard pops, done pulses
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_low_at_done", busy, 0);
    end
    if (inReady) begin
      chk("wri_follows_valid", wri, inValid);
      chk("incnten_follows_valid", inCntEn, inValid);
    end
    if (outValid && sb_en) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        chk("result_value", data_out, sb[0]);
        if (outReady) begin
          void'(sb.pop_front());
        end else begin
          chk("rdo_held_in_stall", rdo, 1);
          chk("no_outcnten_in_stall", outCntEn, 0);
        end
      end
    end
  end

  // Reference: each neuron output is bias plus the dot product of inputs and its weights
  task automatic push_expected();
    for (int j = 0; j < OUT; j++) begin
      int s = b_vec[j];
      for (int i = 0; i < IN; i++) s += x_vec[i] * w_mat[j][i];
      sb.push_back(s);
    end
  endtask

  task automatic rand_vectors();
    for (int i = 0; i < IN; i++) x_vec[i] = int'($urandom_range(0, 255)) - 128;
    for (int j = 0; j < OUT; j++) begin
      b_vec[j] = int'($urandom_range(0, 2047)) - 1024;
      for (int i = 0; i < IN; i++) w_mat[j][i] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic run_pass(input bit tog, input bit stall, input bit lat, input bit mid_start,
                          input bit faulty);
    int t0, dc0, stall_cnt, n;
    if (!faulty) push_expected();
    sb_en = !faulty;
    dc0 = done_cnt;
    stall_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; inValid = tog ? 1'b0 : 1'b1; outReady = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_cleared_by_start", err, 0);
    n = 0;
    while (done_cnt == dc0 && n < 500) begin
      if (tog) inValid = ~inValid;
      if (mid_start) start = (n == 2);
      if (stall) begin
        if (outValid && popped == 1 && stall_cnt < 3) begin
          outReady = 1'b0; stall_cnt++;
        end else begin
          outReady = 1'b1;
        end
      end
      @(posedge clk); #1;
      n++;
    end
    chk("done_pulses", done_cnt - dc0, 1);
    if (lat) chk("latency", done_cyc - t0, LAT);
    if (!faulty) begin
      chk("results_drained", sb.size(), 0);
      chk("err_low_after_pass", err, 0);
    end
    start = 1'b0; inValid = 1'b0; outReady = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; inValid = 1'b0; outReady = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("outputs_in_reset", all_outs, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("outputs_after_reset", all_outs, 0);

    // Unit weights, zero bias, inputs 1..4 back-to-back
    for (int i = 0; i < IN; i++) x_vec[i] = i + 1;
    for (int j = 0; j < OUT; j++) begin
      b_vec[j] = 0;
      for (int i = 0; i < IN; i++) w_mat[j][i] = 1;
    end
    run_pass(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // Bias only
    for (int i = 0; i < IN; i++) x_vec[i] = 0;
    b_vec[0] = 5; b_vec[1] = -2; b_vec[2] = 0;
    run_pass(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // Gapped input stream with a start pulse while busy
    for (int i = 0; i < IN; i++) x_vec[i] = i + 1;
    for (int j = 0; j < OUT; j++) begin
      b_vec[j] = 0;
      for (int i = 0; i < IN; i++) w_mat[j][i] = 1;
    end
    run_pass(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    // Back-pressure on the second result
    rand_vectors();
    run_pass(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 6; p++) begin
      rand_vectors();
      run_pass(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
               1'($urandom_range(0, 1)), 1'b0);
    end

    // Abort in the MAC phase of neuron 1
    rand_vectors();
    @(posedge clk); #1;
    start = 1'b1; inValid = 1'b1; outReady = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(rdi && out_cnt_m == 1) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_mac_neuron1", (n < 200) ? 1 : 0, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("outputs_after_abort", all_outs, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_after_abort", all_outs, 0);
    inValid = 1'b0; outReady = 1'b0;
    rand_vectors();
    run_pass(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // calcDone one neuron early must raise a sticky err
    force_cd = 1'b1;
    rand_vectors();
    run_pass(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("err_on_early_calcdone", err, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("err_sticky", err, 1);
    force_cd = 1'b0;
    rand_vectors();
    run_pass(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
